// File: rtl/switch_scan_ctrl.sv
// switch_scan_ctrl: periodic switch sampler with debounce, change flag and CPU read handshake.
// Optional irq output is enabled by defining SWITCH_SCAN_IRQ_EN.
module switch_scan_ctrl #(
  parameter int SAMPLE_DIV = 100000,
  parameter int STABLE_CNT = 4
) (
  input  logic        switclk,
  input  logic        switrst,
  output logic        sw_read,
  input  logic [15:0] sw_rdata,
  input  logic        cpu_rd_req,
  output logic        cpu_rd_ack,
  output logic [15:0] cpu_rdata,
  input  logic        chg_clr,
  output logic        chg_flag
`ifdef SWITCH_SCAN_IRQ_EN
  ,
  output logic        irq
`endif
);
  localparam int DW = $clog2(SAMPLE_DIV);
  typedef enum logic [2:0] {IDLE, STROBE, CAPTURE, DEBOUNCE, RESP} state_e;
  state_e state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic tick, tick_pend_q, tick_pend_d, deb, chg_set, chg_flag_d;
  logic [7:0] samp_q, samp_d, cand_q, cand_d, stable_q, stable_d;
  logic [3:0] cnt_q, cnt_d, cnt_upd;
  logic sw_read_d, cpu_rd_ack_d;
  logic [15:0] cpu_rdata_d;
  logic unused_hi;
  assign unused_hi = ^sw_rdata[15:8];
  always_ff @(posedge switclk or posedge switrst) begin
    if (switrst) state_q <= IDLE;
    else state_q <= state_d;
  end
  // The CPU wins over a pending sample; a tick seen in IDLE strobes on the very next cycle.
  always_comb begin
    state_d = IDLE;
    unique case (state_q)
      IDLE:     state_d = cpu_rd_req ? RESP : (tick | tick_pend_q) ? STROBE : IDLE;
      STROBE:   state_d = CAPTURE;
      CAPTURE:  state_d = DEBOUNCE;
      DEBOUNCE: state_d = IDLE;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end
  always_comb begin
    tick        = div_q == DW'(SAMPLE_DIV - 1);
    div_d       = tick ? '0 : div_q + DW'(1);
    tick_pend_d = tick | (tick_pend_q & (state_q != STROBE));
    samp_d      = state_q == CAPTURE ? sw_rdata[7:0] : samp_q;
    deb         = state_q == DEBOUNCE;
    cnt_upd     = samp_q != cand_q ? 4'd1 : cnt_q >= 4'(STABLE_CNT) ? 4'(STABLE_CNT) : cnt_q + 4'd1;
    cnt_d       = deb ? cnt_upd : cnt_q;
    cand_d      = deb ? samp_q : cand_q;
    chg_set     = deb && cnt_upd == 4'(STABLE_CNT) && samp_q != stable_q;
    stable_d    = chg_set ? samp_q : stable_q;
    chg_flag_d  = chg_set | (chg_flag & ~chg_clr);
  end
  always_comb begin
    sw_read_d    = state_d == STROBE;
    cpu_rd_ack_d = state_d == RESP;
    cpu_rdata_d  = state_d == RESP ? {7'd0, chg_flag_d, stable_d} : cpu_rdata;
  end
  always_ff @(posedge switclk or posedge switrst) begin
    if (switrst) begin
      div_q       <= '0;
      tick_pend_q <= 1'b0;
      samp_q      <= '0;
      cand_q      <= '0;
      cnt_q       <= '0;
      stable_q    <= '0;
      chg_flag    <= 1'b0;
      sw_read     <= 1'b0;
      cpu_rd_ack  <= 1'b0;
      cpu_rdata   <= '0;
    end else begin
      div_q       <= div_d;
      tick_pend_q <= tick_pend_d;
      samp_q      <= samp_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      stable_q    <= stable_d;
      chg_flag    <= chg_flag_d;
      sw_read     <= sw_read_d;
      cpu_rd_ack  <= cpu_rd_ack_d;
      cpu_rdata   <= cpu_rdata_d;
    end
  end
`ifdef SWITCH_SCAN_IRQ_EN
  always_ff @(posedge switclk or posedge switrst) begin
    if (switrst) irq <= 1'b0;
    else irq <= chg_flag;
  end
`endif
endmodule

// File: tb/tb_switch_scan_ctrl.sv
// tb_switch_scan_ctrl: directed vectors for switch_scan_ctrl with SAMPLE_DIV=4, STABLE_CNT=3.
module tb_switch_scan_ctrl;
  logic switclk, switrst, sw_read, cpu_rd_req, cpu_rd_ack, chg_clr, chg_flag;
  logic [15:0] sw_rdata, cpu_rdata;
`ifdef SWITCH_SCAN_IRQ_EN
  logic irq;
`endif
  int errors = 0, checks = 0;
  typedef struct {
    logic [15:0] sw;
    int          n;
    logic        clr;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[12];
  switch_scan_ctrl #(.SAMPLE_DIV(4), .STABLE_CNT(3)) dut (
    .switclk(switclk), .switrst(switrst), .sw_read(sw_read), .sw_rdata(sw_rdata),
    .cpu_rd_req(cpu_rd_req), .cpu_rd_ack(cpu_rd_ack), .cpu_rdata(cpu_rdata),
    .chg_clr(chg_clr), .chg_flag(chg_flag)
`ifdef SWITCH_SCAN_IRQ_EN
    , .irq(irq)
`endif
  );
  initial switclk = 1'b0;
  always #5 switclk = ~switclk;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic negs(input int n);
    for (int i = 0; i < n; i++) @(negedge switclk);
  endtask
  task automatic do_reset();
    @(negedge switclk);
    switrst = 1'b1;
    @(negedge switclk);
    switrst = 1'b0;
  endtask
  task automatic sample(input logic [15:0] v);
    logic found;
    sw_rdata = v;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge switclk);
      found = sw_read;
    end
    chk("sample_strobe_seen", {15'd0, found}, 16'd1);
    negs(3);
  endtask
  task automatic cpu_read(output logic [15:0] d);
    logic got;
    got = 1'b0;
    d = 'x;
    cpu_rd_req = 1'b1;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge switclk);
      if (cpu_rd_ack) begin
        got = 1'b1;
        d = cpu_rdata;
        cpu_rd_req = 1'b0;
      end
    end
    cpu_rd_req = 1'b0;
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL cpu_read_timeout: got no ack expected ack within 12 cycles");
    end
  endtask
  initial begin
    logic [15:0] d;
    vecs[0]  = '{16'h003C, 1, 1'b0, 16'h0000};
    vecs[1]  = '{16'h0000, 1, 1'b0, 16'h0000};
    vecs[2]  = '{16'h003C, 1, 1'b0, 16'h0000};
    vecs[3]  = '{16'h0000, 1, 1'b0, 16'h0000};
    vecs[4]  = '{16'h00A5, 2, 1'b0, 16'h0000};
    vecs[5]  = '{16'h00A5, 1, 1'b0, 16'h01A5};
    vecs[6]  = '{16'h00A5, 1, 1'b0, 16'h01A5};
    vecs[7]  = '{16'hFF5A, 1, 1'b1, 16'h00A5};
    vecs[8]  = '{16'hFF5A, 1, 1'b0, 16'h00A5};
    vecs[9]  = '{16'hFF5A, 1, 1'b0, 16'h015A};
    vecs[10] = '{16'h0033, 2, 1'b1, 16'h005A};
    vecs[11] = '{16'h0033, 1, 1'b0, 16'h0133};
    switrst = 1'b1; sw_rdata = 16'h0000; cpu_rd_req = 1'b0; chg_clr = 1'b0;
    #12;
    chk("rst_sw_read", {15'd0, sw_read}, 16'd0);
    chk("rst_ack", {15'd0, cpu_rd_ack}, 16'd0);
    chk("rst_rdata", cpu_rdata, 16'h0000);
    chk("rst_chg_flag", {15'd0, chg_flag}, 16'd0);
`ifdef SWITCH_SCAN_IRQ_EN
    chk("rst_irq", {15'd0, irq}, 16'd0);
`endif
    @(negedge switclk);
    switrst = 1'b0;
    for (int v = 0; v < 12; v++) begin
      if (vecs[v].clr) begin
        chg_clr = 1'b1;
        @(negedge switclk);
        chg_clr = 1'b0;
      end
      for (int k = 0; k < vecs[v].n; k++) sample(vecs[v].sw);
      cpu_read(d);
      chk($sformatf("vec%0d_rdata", v), d, vecs[v].exp);
    end
    negs(9);
    chk("rdata_hold", cpu_rdata, 16'h0133);
    // Reset in the middle of a strobe must clear everything asynchronously.
    sample(16'h00F0);
    begin
      logic found;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        @(negedge switclk);
        found = sw_read;
      end
      chk("midrst_strobe_seen", {15'd0, found}, 16'd1);
    end
    #1 switrst = 1'b1;
    #1;
    chk("midrst_sw_read", {15'd0, sw_read}, 16'd0);
    chk("midrst_chg_flag", {15'd0, chg_flag}, 16'd0);
    chk("midrst_rdata", cpu_rdata, 16'h0000);
    chk("midrst_ack", {15'd0, cpu_rd_ack}, 16'd0);
    sw_rdata = 16'h0000;
    @(negedge switclk);
    switrst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge switclk);
      chk($sformatf("postrst_quiet%0d", i), {15'd0, sw_read}, 16'd0);
    end
    @(negedge switclk);
    chk("postrst_first_strobe", {15'd0, sw_read}, 16'd1);
    // CPU request in the tick cycle: ack first with old data, then the strobe.
    sw_rdata = 16'h0077;
    do_reset();
    negs(3);
    cpu_rd_req = 1'b1;
    @(negedge switclk);
    chk("coll_ack", {15'd0, cpu_rd_ack}, 16'd1);
    chk("coll_old_data", cpu_rdata, 16'h0000);
    chk("coll_no_strobe", {15'd0, sw_read}, 16'd0);
    cpu_rd_req = 1'b0;
    @(negedge switclk);
    chk("coll_ack_single", {15'd0, cpu_rd_ack}, 16'd0);
    chk("coll_idle", {15'd0, sw_read}, 16'd0);
    @(negedge switclk);
    chk("coll_tick_kept", {15'd0, sw_read}, 16'd1);
    // Clear racing a change-set: the set must win.
    sw_rdata = 16'h0011;
    do_reset();
    negs(15);
    chk("race_first_set", {15'd0, chg_flag}, 16'd1);
    @(negedge switclk);
    chg_clr = 1'b1;
    sw_rdata = 16'h0022;
    @(negedge switclk);
    chg_clr = 1'b0;
    chk("race_pre_clear", {15'd0, chg_flag}, 16'd0);
    negs(9);
    chg_clr = 1'b1;
    @(negedge switclk);
    chg_clr = 1'b0;
    chk("race_set_wins", {15'd0, chg_flag}, 16'd1);
    @(negedge switclk);
`ifdef SWITCH_SCAN_IRQ_EN
    chk("race_irq_follows", {15'd0, irq}, 16'd1);
`endif
    chg_clr = 1'b1;
    @(negedge switclk);
    chg_clr = 1'b0;
    chk("race_clear_alone", {15'd0, chg_flag}, 16'd0);
    @(negedge switclk);
`ifdef SWITCH_SCAN_IRQ_EN
    chk("race_irq_cleared", {15'd0, irq}, 16'd0);
`endif
    cpu_read(d);
    chk("race_rdata", d, 16'h0022);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end
endmodule
